// File: rtl/vdp_host_pkg.sv
// Shared types and helpers for the VDP host bus initiator: op codes, VDP mode
// encodings, FSM states and the per-op bus-phase table.
package vdp_host_pkg;

    localparam logic [2:0] OP_SELECT    = 3'd0;
    localparam logic [2:0] OP_SET_REG   = 3'd1;
    localparam logic [2:0] OP_SET_REG16 = 3'd2;
    localparam logic [2:0] OP_GET_REG   = 3'd3;
    localparam logic [2:0] OP_VRAM_WR   = 3'd4;
    localparam logic [2:0] OP_VRAM_RD   = 3'd5;

    localparam logic [1:0] MODE_SELECT = 2'b00;
    localparam logic [1:0] MODE_REG    = 2'b01;
    localparam logic [1:0] MODE_DATA   = 2'b10;
    localparam logic [1:0] MODE_IDLE   = 2'b11;

    typedef enum logic [1:0] {
        H_IDLE,
        H_PACE,
        H_RUN
    } host_state_e;

    typedef enum logic [1:0] {
        P_IDLE,
        P_SETUP,
        P_STROBE,
        P_HOLD
    } phase_state_e;

    typedef struct packed {
        logic [1:0] mode;
        logic       is_read;
        logic [7:0] data;
    } phase_t;

    function automatic logic [2:0] op_phases(input logic [2:0] op);
        logic [2:0] n;
        case (op)
            OP_SELECT:    n = 3'd1;
            OP_SET_REG:   n = 3'd2;
            OP_SET_REG16: n = 3'd4;
            OP_GET_REG:   n = 3'd2;
            OP_VRAM_WR:   n = 3'd1;
            OP_VRAM_RD:   n = 3'd1;
            default:      n = 3'd0;
        endcase
        return n;
    endfunction

    function automatic phase_t op_phase(input logic [2:0]  op,
                                        input logic [3:0]  regi,
                                        input logic [15:0] arg,
                                        input logic [2:0]  idx);
        phase_t     p;
        logic [3:0] reg_next;
        reg_next  = regi + 4'd1;
        p.mode    = MODE_IDLE;
        p.is_read = 1'b0;
        p.data    = 8'h00;
        case (op)
            OP_SELECT: begin
                p.mode = MODE_SELECT;
                p.data = arg[7:0];
            end
            OP_SET_REG: begin
                p.mode = idx[0] ? MODE_REG : MODE_SELECT;
                p.data = idx[0] ? arg[7:0] : {4'h0, regi};
            end
            OP_SET_REG16: begin
                case (idx[1:0])
                    2'd0:    begin p.mode = MODE_SELECT; p.data = {4'h0, regi};     end
                    2'd1:    begin p.mode = MODE_REG;    p.data = arg[7:0];         end
                    2'd2:    begin p.mode = MODE_SELECT; p.data = {4'h0, reg_next}; end
                    default: begin p.mode = MODE_REG;    p.data = arg[15:8];        end
                endcase
            end
            OP_GET_REG: begin
                p.mode    = idx[0] ? MODE_REG : MODE_SELECT;
                p.is_read = idx[0];
                p.data    = idx[0] ? 8'h00 : {4'h0, regi};
            end
            OP_VRAM_WR: begin
                p.mode = MODE_DATA;
                p.data = arg[7:0];
            end
            OP_VRAM_RD: begin
                p.mode    = MODE_DATA;
                p.is_read = 1'b1;
            end
            default: ;
        endcase
        return p;
    endfunction

    function automatic logic is_vram_op(input logic [2:0] op);
        return (op == OP_VRAM_WR) || (op == OP_VRAM_RD);
    endfunction

    // SET_REG16 on reg 15 wraps its second write onto reg 0, so it counts too.
    function automatic logic loads_gap(input logic [2:0] op, input logic [3:0] regi);
        logic hit;
        case (op)
            OP_VRAM_WR, OP_VRAM_RD: hit = 1'b1;
            OP_SET_REG:             hit = (regi < 4'd4);
            OP_SET_REG16:           hit = (regi < 4'd4) || (regi == 4'hF);
            default:                hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/vdp_host_phase.sv
// Single bus-phase strobe generator: SETUP (1) -> STROBE -> HOLD, with a
// start/done handshake that lets phases chain without idle cycles.
module vdp_host_phase
    import vdp_host_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_i,
    input  logic [1:0] mode_i,
    input  logic       is_read_i,
    input  logic [7:0] data_i,
    output logic       done_o,
    output logic       capture_o,
    output logic [1:0] vdp_mode_o,
    output logic       vdp_read_o,
    output logic       vdp_write_o,
    output logic [7:0] vdp_wdata_o
);

    localparam int unsigned MAXC = (STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    phase_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    mode_q, mode_d;
    logic [7:0]    data_q, data_d;
    logic          rd_q, rd_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= P_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_IDLE;
            data_q  <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        data_d    = data_q;
        rd_d      = rd_q;
        done_o    = 1'b0;
        capture_o = 1'b0;
        case (state_q)
            P_IDLE: begin
                if (start_i) begin
                    state_d = P_SETUP;
                    mode_d  = mode_i;
                    data_d  = data_i;
                    rd_d    = is_read_i;
                end
            end
            P_SETUP: begin
                state_d = P_STROBE;
                cnt_d   = CW'(STROBE_CYCLES - 1);
            end
            P_STROBE: begin
                if (cnt_q == '0) begin
                    capture_o = rd_q;
                    state_d   = P_HOLD;
                    cnt_d     = CW'(HOLD_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            P_HOLD: begin
                if (cnt_q == '0) begin
                    done_o = 1'b1;
                    // Chained phase: jump straight to SETUP with the next descriptor.
                    if (start_i) begin
                        state_d = P_SETUP;
                        mode_d  = mode_i;
                        data_d  = data_i;
                        rd_d    = is_read_i;
                    end else begin
                        state_d = P_IDLE;
                        mode_d  = MODE_IDLE;
                        data_d  = '0;
                        rd_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = P_IDLE;
        endcase
    end

    assign vdp_mode_o  = mode_q;
    assign vdp_wdata_o = data_q;
    assign vdp_read_o  = (state_q == P_STROBE) &&  rd_q;
    assign vdp_write_o = (state_q == P_STROBE) && !rd_q;

endmodule

// File: rtl/vdp_host.sv
// VDP host bus initiator: sequences per-op bus phases and owns VRAM pacing.
// Optional macro VDP_HOST_PACE_EN enables the VRAM gap counter and PACE state.
module vdp_host
    import vdp_host_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 2,
    parameter int unsigned VRAM_GAP      = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [3:0]  cmd_reg,
    input  logic [15:0] cmd_arg,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        busy,
    output logic [1:0]  vdp_mode,
    output logic        vdp_read,
    output logic        vdp_write,
    output logic [7:0]  vdp_wdata,
    input  logic [7:0]  vdp_rdata
);

    host_state_e state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [3:0]  reg_q, reg_d;
    logic [15:0] arg_q, arg_d;
    logic [2:0]  idx_q, idx_d;
    logic        rsp_valid_q;
    logic [7:0]  rsp_data_q;

    logic        accept;
    logic        start;
    logic        done;
    logic        capture;
    logic        op_end;
    logic        pace_hold;
    logic        pace_clear;
    logic [2:0]  sel_op;
    logic [3:0]  sel_reg;
    logic [15:0] sel_arg;
    logic [2:0]  sel_idx;
    phase_t      desc;

    assign cmd_ready = (state_q == H_IDLE);
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

`ifdef VDP_HOST_PACE_EN
    localparam int unsigned GW = $clog2(VRAM_GAP + 1);
    logic [GW-1:0] gap_q, gap_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) gap_q <= '0;
        else          gap_q <= gap_d;
    end

    always_comb begin
        gap_d = gap_q;
        if (op_end && loads_gap(op_q, reg_q)) gap_d = GW'(VRAM_GAP);
        else if (gap_q != '0)                 gap_d = gap_q - GW'(1);
    end

    assign pace_hold  = is_vram_op(cmd_op) && (gap_q != '0);
    assign pace_clear = (gap_q == '0);
`else
    logic unused_ok;
    assign unused_ok  = ^{VRAM_GAP, op_end};
    assign pace_hold  = 1'b0;
    assign pace_clear = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= H_IDLE;
            op_q        <= '0;
            reg_q       <= '0;
            arg_q       <= '0;
            idx_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            reg_q       <= reg_d;
            arg_q       <= arg_d;
            idx_q       <= idx_d;
            rsp_valid_q <= capture;
            if (capture) rsp_data_q <= vdp_rdata;
        end
    end

    // idx_q counts phases already launched, so it also indexes the next one.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        reg_d   = reg_q;
        arg_d   = arg_q;
        idx_d   = idx_q;
        start   = 1'b0;
        op_end  = 1'b0;
        sel_op  = op_q;
        sel_reg = reg_q;
        sel_arg = arg_q;
        sel_idx = idx_q;
        case (state_q)
            H_IDLE: begin
                if (accept && (op_phases(cmd_op) != 3'd0)) begin
                    op_d  = cmd_op;
                    reg_d = cmd_reg;
                    arg_d = cmd_arg;
                    idx_d = 3'd0;
                    if (pace_hold) begin
                        state_d = H_PACE;
                    end else begin
                        start   = 1'b1;
                        sel_op  = cmd_op;
                        sel_reg = cmd_reg;
                        sel_arg = cmd_arg;
                        sel_idx = 3'd0;
                        idx_d   = 3'd1;
                        state_d = H_RUN;
                    end
                end
            end
            H_PACE: begin
                if (pace_clear) begin
                    start   = 1'b1;
                    idx_d   = idx_q + 3'd1;
                    state_d = H_RUN;
                end
            end
            H_RUN: begin
                if (done) begin
                    if (idx_q == op_phases(op_q)) begin
                        op_end  = 1'b1;
                        state_d = H_IDLE;
                    end else begin
                        start = 1'b1;
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = H_IDLE;
        endcase
        desc = op_phase(sel_op, sel_reg, sel_arg, sel_idx);
    end

    vdp_host_phase #(
        .STROBE_CYCLES(STROBE_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES)
    ) u_phase (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (start),
        .mode_i     (desc.mode),
        .is_read_i  (desc.is_read),
        .data_i     (desc.data),
        .done_o     (done),
        .capture_o  (capture),
        .vdp_mode_o (vdp_mode),
        .vdp_read_o (vdp_read),
        .vdp_write_o(vdp_write),
        .vdp_wdata_o(vdp_wdata)
    );

endmodule

// File: tb/tb_vdp_host.sv
// Self-checking bench for vdp_host: behavioural VDP model, strobe-timing
// monitor and a response scoreboard.
module tb_vdp_host;
    import vdp_host_pkg::*;

    localparam int unsigned SC  = 2;
    localparam int unsigned HC  = 2;
    localparam int unsigned GAP = 24;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [3:0]  cmd_reg = '0;
    logic [15:0] cmd_arg = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        busy;
    logic [1:0]  vdp_mode;
    logic        vdp_read;
    logic        vdp_write;
    logic [7:0]  vdp_wdata;
    logic [7:0]  vdp_rdata;

    always #5 clk = ~clk;

    vdp_host #(
        .STROBE_CYCLES(SC),
        .HOLD_CYCLES  (HC),
        .VRAM_GAP     (GAP)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_reg  (cmd_reg),
        .cmd_arg  (cmd_arg),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .busy     (busy),
        .vdp_mode (vdp_mode),
        .vdp_read (vdp_read),
        .vdp_write(vdp_write),
        .vdp_wdata(vdp_wdata),
        .vdp_rdata(vdp_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // VDP model: regs 0/1 = write pointer, regs 2/3 = read pointer.
    logic [7:0]  vram [0:65535];
    logic [7:0]  regs [0:15];
    logic [3:0]  sel = '0;
    logic        prev_w = 1'b0;
    logic        prev_r = 1'b0;
    logic [15:0] mptr;
    logic [9:0]  wlog[$];

    assign vdp_rdata = (vdp_mode == MODE_REG)  ? regs[sel] :
                       (vdp_mode == MODE_DATA) ? vram[{regs[3], regs[2]}] : 8'h00;

    always @(negedge clk) begin
        if (prev_w && !vdp_write) begin
            wlog.push_back({vdp_mode, vdp_wdata});
            case (vdp_mode)
                MODE_SELECT: sel = vdp_wdata[3:0];
                MODE_REG:    regs[sel] = vdp_wdata;
                MODE_DATA: begin
                    mptr = {regs[1], regs[0]};
                    vram[mptr] = vdp_wdata;
                    mptr = mptr + 16'd1;
                    {regs[1], regs[0]} = mptr;
                end
                default: ;
            endcase
        end
        if (prev_r && !vdp_read && vdp_mode == MODE_DATA) begin
            mptr = {regs[3], regs[2]} + 16'd1;
            {regs[3], regs[2]} = mptr;
        end
        prev_w = vdp_write;
        prev_r = vdp_read;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Strobe width, post-strobe stability and read/write exclusion.
    int         srun = 0;
    int         hold_left = 0;
    logic [9:0] strobe_val = '0;
    int         strobe_rises = 0;
    int         last_wrise = 0;
    int         rw_both = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            srun = 0;
            hold_left = 0;
        end else begin
            if (vdp_read && vdp_write) rw_both++;
            if (vdp_read || vdp_write) begin
                if (srun == 0) begin
                    strobe_rises++;
                    if (vdp_write) last_wrise = cyc;
                end
                srun++;
                strobe_val = {vdp_mode, vdp_wdata};
            end else if (srun != 0) begin
                check_eq("strobe_width", srun, SC);
                srun = 0;
                hold_left = HC;
            end
            if (hold_left > 0) begin
                check_eq("hold_stable", {vdp_mode, vdp_wdata}, strobe_val);
                hold_left--;
            end
        end
    end

    logic [7:0] exp_q[$];
    logic       prev_rsp = 1'b0;
    always @(negedge clk) begin
        if (reset_n && rsp_valid) begin
            check_eq("rsp_single_pulse", prev_rsp, 1'b0);
            if (exp_q.size() == 0) check_eq("rsp_unexpected", rsp_valid, 1'b0);
            else                   check_eq("rsp_data", rsp_data, exp_q.pop_front());
        end
        prev_rsp = rsp_valid;
    end

    int ready_cyc = 0;

    task automatic send(input logic [2:0] op, input logic [3:0] r, input logic [15:0] a,
                        output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check_eq("ready_timeout", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_reg   = r;
        cmd_arg   = a;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom_range(0, 7));
        cmd_arg   = 16'($urandom);
        lat = 1;
        while (!cmd_ready && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!cmd_ready) check_eq("done_timeout", cmd_ready, 1'b1);
        ready_cyc = cyc;
    endtask

    task automatic check_wlog(input string tag, input int n, input logic [9:0] e0,
                              input logic [9:0] e1, input logic [9:0] e2, input logic [9:0] e3);
        logic [9:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        check_eq({tag, "_count"}, wlog.size(), n);
        for (int i = 0; i < n && i < wlog.size(); i++)
            check_eq($sformatf("%s_%0d", tag, i), wlog[i], e[i]);
    endtask

    initial begin
        int         lat;
        int         wr1_ready;
        int         rises0;
        int         n;
        logic [15:0] p0;
        logic [7:0]  v0;

        for (int i = 0; i < 65536; i++) vram[i] = 8'h00;
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        regs[7] = 8'h10;

        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_mode", vdp_mode, MODE_IDLE);
        check_eq("rst_strobes", {vdp_read, vdp_write}, 2'b00);
        check_eq("rst_wdata", vdp_wdata, 8'h00);
        check_eq("rst_rsp", {rsp_valid, rsp_data}, 9'h000);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_ready", {cmd_ready, busy}, 2'b10);

        exp_q.push_back(8'h10);
        send(OP_GET_REG, 4'd7, 16'h0000, lat);
        check_eq("getreg7_lat", lat, 1 + 2 * (1 + SC + HC));

        wlog.delete();
        send(OP_SET_REG, 4'd5, 16'h003C, lat);
        check_eq("setreg_lat", lat, 11);
        check_wlog("setreg_bus", 2, {MODE_SELECT, 8'h05}, {MODE_REG, 8'h3C}, 10'h0, 10'h0);
        check_eq("model_reg5", regs[5], 8'h3C);

        exp_q.push_back(8'h3C);
        send(OP_GET_REG, 4'd5, 16'hFFFF, lat);

        send(OP_SET_REG16, 4'd0, 16'h1234, lat);
        check_eq("setreg16_lat", lat, 21);
        send(OP_VRAM_WR, 4'd0, 16'h00AB, lat);
        wr1_ready = ready_cyc;
`ifndef VDP_HOST_PACE_EN
        check_eq("vram_wr_lat", lat, 6);
`endif
        send(OP_VRAM_WR, 4'd0, 16'h00CD, lat);
`ifdef VDP_HOST_PACE_EN
        check_eq("pace_gap", ((last_wrise - 1) - wr1_ready) >= GAP, 1'b1);
`else
        check_eq("vram_wr2_lat", lat, 6);
`endif
        check_eq("vram_1234", vram[16'h1234], 8'hAB);
        check_eq("vram_1235", vram[16'h1235], 8'hCD);

        vram[16'h1234] = 8'h5A;
        send(OP_SET_REG16, 4'd2, 16'h1234, lat);
        exp_q.push_back(8'h5A);
        send(OP_VRAM_RD, 4'd0, 16'h0000, lat);
`ifndef VDP_HOST_PACE_EN
        check_eq("vram_rd_lat", lat, 6);
`endif
        check_eq("rd_ptr", {regs[3], regs[2]}, 16'h1235);

        wlog.delete();
        send(OP_SET_REG16, 4'd15, 16'hBEEF, lat);
        check_wlog("wrap_bus", 4, {MODE_SELECT, 8'h0F}, {MODE_REG, 8'hEF},
                   {MODE_SELECT, 8'h00}, {MODE_REG, 8'hBE});
        check_eq("model_reg15", regs[15], 8'hEF);
        check_eq("model_reg0", regs[0], 8'hBE);

        rises0 = strobe_rises;
        send(3'd6, 4'd3, 16'h5555, lat);
        check_eq("op6_lat", lat, 1);
        send(3'd7, 4'd3, 16'h5555, lat);
        check_eq("op7_lat", lat, 1);
        check_eq("op67_no_strobe", strobe_rises, rises0);

        // Reset during the strobe of a VRAM write.
        p0 = {regs[1], regs[0]};
        v0 = vram[p0];
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_VRAM_WR;
        cmd_arg   = 16'h0077;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (!vdp_write && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("rst_wr_strobe_seen", vdp_write, 1'b1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_async_strobes", {vdp_read, vdp_write}, 2'b00);
        check_eq("rst_async_mode", vdp_mode, MODE_IDLE);
        check_eq("rst_async_rsp", rsp_data, 8'h00);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_release_ready", cmd_ready, 1'b1);
        check_eq("rst_vram_unchanged", vram[p0], v0);
        check_eq("rst_ptr_unchanged", {regs[1], regs[0]}, p0);

        exp_q.push_back(8'h3C);
        send(OP_GET_REG, 4'd5, 16'h0000, lat);
        check_eq("post_rst_getreg_lat", lat, 11);

        repeat (4) @(posedge clk);
        #1;
        check_eq("scoreboard_empty", exp_q.size(), 0);
        check_eq("rw_exclusive", rw_both, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
